// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared serializer state encoding, byte width and clamp helper
package img_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_R = 2'd1,
        SEND_G = 2'd2,
        SEND_B = 2'd3
    } ser_state_t;

    localparam int BYTE_W = 8;

    // Saturate a zero-extended channel value to one byte.
    function automatic logic [BYTE_W-1:0] clamp_byte(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[BYTE_W-1:0];
    endfunction

endpackage

// File: rtl/chan_clamp.sv
// rtl/chan_clamp.sv - saturate one IN_W-bit channel to a byte and flag overflow
module chan_clamp
    import img_pkg::*;
#(
    parameter int IN_W = 10
) (
    input  logic [IN_W-1:0]   din,
    output logic [BYTE_W-1:0] dout,
    output logic              ovf
);

    logic [31:0] wide;

    assign wide = 32'(din);
    assign dout = clamp_byte(wide);
    assign ovf  = (wide > 32'd255);

endmodule

// File: rtl/sepia_byte_serializer.sv
// rtl/sepia_byte_serializer.sv - pixel to R,G,B byte serializer; SATURATION_COUNT_EN adds sat_count
module sepia_byte_serializer
    import img_pkg::*;
#(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512,
    parameter int IN_W   = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_r,
    input  logic [IN_W-1:0] in_g,
    input  logic [IN_W-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic            out_last,
    output logic            frame_done
`ifdef SATURATION_COUNT_EN
    ,
    output logic [31:0]     sat_count
`endif
);

    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPIX - 1);

    ser_state_t        state;
    logic [23:0]       pix;
    logic [CNT_W-1:0]  pix_cnt;
    logic [7:0]        r_c, g_c, b_c;
    logic              r_ovf, g_ovf, b_ovf;
    logic              accept;

    chan_clamp #(.IN_W(IN_W)) u_clamp_r (.din(in_r), .dout(r_c), .ovf(r_ovf));
    chan_clamp #(.IN_W(IN_W)) u_clamp_g (.din(in_g), .dout(g_c), .ovf(g_ovf));
    chan_clamp #(.IN_W(IN_W)) u_clamp_b (.din(in_b), .dout(b_c), .ovf(b_ovf));

    // A new pixel may be taken in the same cycle the B byte leaves.
    assign in_ready = !rst && ((state == IDLE) || (state == SEND_B && out_ready));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pix        <= 24'd0;
            pix_cnt    <= '0;
            out_valid  <= 1'b0;
            out_data   <= 8'd0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        pix       <= {r_c, g_c, b_c};
                        out_data  <= r_c;
                        out_valid <= 1'b1;
                        state     <= SEND_R;
                    end
                end
                SEND_R: begin
                    if (out_ready) begin
                        out_data <= pix[15:8];
                        state    <= SEND_G;
                    end
                end
                SEND_G: begin
                    if (out_ready) begin
                        out_data <= pix[7:0];
                        out_last <= (pix_cnt == LAST_IDX);
                        state    <= SEND_B;
                    end
                end
                SEND_B: begin
                    if (out_ready) begin
                        out_last   <= 1'b0;
                        frame_done <= out_last;
                        pix_cnt    <= (pix_cnt == LAST_IDX) ? '0 : pix_cnt + 1'b1;
                        if (accept) begin
                            pix      <= {r_c, g_c, b_c};
                            out_data <= r_c;
                            state    <= SEND_R;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SATURATION_COUNT_EN
    logic [1:0]  sat_inc;
    logic [32:0] sat_sum;

    assign sat_inc = 2'(r_ovf) + 2'(g_ovf) + 2'(b_ovf);
    assign sat_sum = {1'b0, sat_count} + 33'(sat_inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count <= 32'd0;
        end else if (accept) begin
            sat_count <= sat_sum[32] ? 32'hFFFF_FFFF : sat_sum[31:0];
        end
    end
`else
    logic unused_ovf;
    assign unused_ovf = r_ovf ^ g_ovf ^ b_ovf;
`endif

endmodule

// File: tb/tb_sepia_byte_serializer.sv
// tb/tb_sepia_byte_serializer.sv - scoreboard bench for sepia_byte_serializer (WIDTH=4, HEIGHT=2)
module tb_sepia_byte_serializer;

    localparam int IN_W = 10;
    localparam int NPIX = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [IN_W-1:0] in_r = '0, in_g = '0, in_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [7:0]      out_data;
    logic            out_last;
    logic            frame_done;
`ifdef SATURATION_COUNT_EN
    logic [31:0]     sat_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_bytes = 0;
    int last_byte_cyc = 0;
    int model_idx = 0;
    logic fd_exp = 1'b0;
    logic [8:0] exp_q[$];

    sepia_byte_serializer #(.WIDTH(4), .HEIGHT(2), .IN_W(IN_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .frame_done(frame_done)
`ifdef SATURATION_COUNT_EN
        , .sat_count(sat_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] clampm(input int v);
        return (v > 255) ? 8'hFF : v[7:0];
    endfunction

    // Monitor: pop expected byte on every output transfer and track frame_done.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            fd_exp = 1'b0;
        end else begin
            check("frame_done", {31'd0, frame_done}, {31'd0, fd_exp});
            fd_exp = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
                    check("out_last", {31'd0, out_last}, {31'd0, e[8]});
                end
                fd_exp = out_last;
                n_bytes++;
                last_byte_cyc = cyc;
            end
        end
    end

    // Waits for the accepting negedge of the currently driven pixel and queues its bytes.
    task automatic drive_pixel(input int r, input int g, input int b);
        bit ok = 0;
        in_r = IN_W'(r); in_g = IN_W'(g); in_b = IN_W'(b);
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            exp_q.push_back({1'b0, clampm(r)});
            exp_q.push_back({1'b0, clampm(g)});
            exp_q.push_back({model_idx == NPIX - 1, clampm(b)});
            model_idx = (model_idx == NPIX - 1) ? 0 : model_idx + 1;
        end
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    int c0, b0;
    logic [7:0] hold_g;

    initial begin
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_data", {24'd0, out_data}, 0);
        check("rst_out_last", {31'd0, out_last}, 0);
        check("rst_frame_done", {31'd0, frame_done}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("idle_in_ready", {31'd0, in_ready}, 1);

        out_ready = 1'b1;
        drive_pixel(344, 300, 100);
        in_valid = 1'b0;
        drain();
`ifdef SATURATION_COUNT_EN
        check("sat_count", sat_count, 2);
`endif

        b0 = n_bytes;
        for (int p = 0; p < 100; p++) begin
            drive_pixel((p * 37) % 1024, (p * 11 + 200) % 1024, 255 + (p % 3));
            if (p == 0) c0 = cyc - 1;
        end
        in_valid = 1'b0;
        drain();
        check("stream_bytes", n_bytes - b0, 300);
        check("stream_span", last_byte_cyc - c0, 300);

        out_ready = 1'b0;
        drive_pixel(5, 600, 77);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        hold_g = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, out_valid}, 1);
            check("stall_data", {24'd0, out_data}, {24'd0, hold_g});
            check("stall_in_ready", {31'd0, in_ready}, 0);
        end
        in_valid = 1'b1;
        @(negedge clk);
        check("stall_no_accept", {31'd0, in_ready}, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        out_ready = 1'b0;
        drive_pixel(1, 2, 3);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        model_idx = 0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 0);
        check("mid_rst_data", {24'd0, out_data}, 0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        drive_pixel(400, 10, 1023);
        for (int p = 1; p < NPIX + 1; p++) drive_pixel(p * 20, 256 - p, p * 100);
        in_valid = 1'b0;
        drain();
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
